// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request side, slave is the subtractor itself.
interface serial_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bo;
  logic             ovf;

  modport master (output start, a, b, bi,
                  input  busy, done, diff, bo, ovf);
  modport slave  (input  start, a, b, bi,
                  output busy, done, diff, bo, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bi, one bit per clock LSB first, using a single shared borrow cell.
// Define SERIAL_SUB_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one result bit per edge, counter selects the bit
// DONE  | result valid for one cycle; a new start is accepted here
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  sif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic a_bit, b_bit, d_bit, br_n, last_bit;

  always_comb begin
    a_bit    = a_q[cnt_q];
    b_bit    = b_q[cnt_q];
    d_bit    = a_bit ^ b_bit ^ br_q;
    br_n     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));

    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (sif.start) begin
          a_d     = sif.a;
          b_d     = sif.b;
          br_d    = sif.bi;
          diff_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // New bit enters at the MSB so the word lands in natural order after WIDTH shifts.
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        br_d   = br_n;
        cnt_d  = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          bo_d    = br_n;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = br_q ^ br_n;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sif.busy = busy_q;
  assign sif.done = done_q;
  assign sif.diff = diff_q;
  assign sif.bo   = bo_q;
`ifdef SERIAL_SUB_OVF_EN
  assign sif.ovf  = ovf_q;
`else
  assign sif.ovf  = 1'b0;
`endif

endmodule
